pipeline_run_controller: RTL and testbench

Sequences the five-stage MIPS pipeline for the debug/run path. It accepts run, step and stop commands and gates the pipeline-register enables. It inserts load-use bubbles and drains the pipeline after a halt instruction reaches decode. It sits between the debug command interface, the hazard detection logic and the IF/ID, ID/EX, EX/MEM and MEM/WB registers plus the PC.

---
 rtl/pipeline_ctrl_pkg.sv | 21 ++
 rtl/sat_counter.sv | 18 +
 rtl/pipeline_run_controller.sv | 99 +++++++++
 tb/tb_pipeline_run_controller.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared state/command encodings and defaults for the pipeline run controller
package pipeline_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        STEP   = 3'd2,
        DRAIN  = 3'd3,
        HALTED = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_RUN  = 2'b01,
        CMD_STEP = 2'b10,
        CMD_STOP = 2'b11
    } cmd_t;

    localparam int N_STAGES_DEF = 5;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with increment enable, synchronous clear and saturation at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    // clear wins; otherwise count enabled cycles and hold at all-ones
    always_ff @(posedge clk)
        if (clr)
            count <= '0;
        else if (en && count != '1)
            count <= count + W'(1);

endmodule

// File: rtl/pipeline_run_controller.sv
// pipeline_run_controller: run/step/stop sequencing, load-use bubbles and halt drain for a MIPS pipeline
// Optional executed-cycle counter is built only when PIPELINE_CYCLE_COUNTER_EN is defined.
module pipeline_run_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int N_STAGES     = N_STAGES_DEF,
    parameter int NB_CYCLE_CNT = 32,
    parameter int NB_CMD       = 2
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_cmd_valid,
    input  logic [NB_CMD-1:0]       i_cmd,
    output logic                    o_cmd_ready,
    input  logic                    i_halt_detected,
    input  logic                    i_load_use_hazard,
    output logic                    o_pc_enb,
    output logic                    o_if_id_enb,
    output logic                    o_pipe_enb,
    output logic                    o_id_ex_flush,
    output logic [2:0]              o_state,
    output logic                    o_done,
    output logic [NB_CYCLE_CNT-1:0] o_cycle_count
);

    localparam int NB_DRAIN = $clog2(N_STAGES);
    localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(N_STAGES - 2);

    state_t              state, next_state;
    logic [NB_DRAIN-1:0] drain_cnt;
    logic                active;
    logic                accept;
    logic                halt;

    assign active  = state == RUN || state == STEP;
    assign accept  = i_cmd_valid && o_cmd_ready;
    // a halt stalled behind a load-use bubble waits until the bubble clears
    assign halt    = active && i_halt_detected && !i_load_use_hazard;
    assign o_state = state;

    // state, drain countdown and registered done pulse
    always_ff @(posedge i_clock)
        if (i_reset) begin
            state     <= IDLE;
            drain_cnt <= '0;
            o_done    <= 1'b0;
        end else begin
            state     <= next_state;
            drain_cnt <= halt ? DRAIN_LOAD : (state == DRAIN ? drain_cnt - NB_DRAIN'(1) : drain_cnt);
            o_done    <= (state == STEP && next_state == IDLE) || (state != HALTED && next_state == HALTED);
        end

    // next-state selection; halt beats a simultaneous STOP
    always_comb begin
        next_state = state;
        case (state)
            IDLE:
                if (accept && i_cmd == NB_CMD'(CMD_RUN))
                    next_state = RUN;
                else if (accept && i_cmd == NB_CMD'(CMD_STEP))
                    next_state = STEP;
            RUN:
                if (halt)
                    next_state = DRAIN;
                else if (accept && i_cmd == NB_CMD'(CMD_STOP))
                    next_state = IDLE;
            STEP:
                next_state = halt ? DRAIN : IDLE;
            DRAIN:
                if (drain_cnt == NB_DRAIN'(1))
                    next_state = HALTED;
            HALTED:
                next_state = HALTED;
            default:
                next_state = IDLE;
        endcase
    end

    // enables follow state and the live hazard input; drain keeps pushing bubbles
    always_comb begin
        o_pc_enb      = active && !i_load_use_hazard;
        o_if_id_enb   = active && !i_load_use_hazard;
        o_pipe_enb    = active || state == DRAIN;
        o_id_ex_flush = (active && i_load_use_hazard) || state == DRAIN;
        o_cmd_ready   = state == IDLE || state == RUN || state == HALTED;
    end

`ifdef PIPELINE_CYCLE_COUNTER_EN
    sat_counter #(.W(NB_CYCLE_CNT)) u_cycle_cnt (
        .clk   (i_clock),
        .clr   (i_reset),
        .en    (o_pipe_enb),
        .count (o_cycle_count)
    );
`else
    assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_run_controller.sv
// tb_pipeline_run_controller: scoreboard bench for pipeline_run_controller
module tb_pipeline_run_controller;

`ifdef PIPELINE_CYCLE_COUNTER_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    // stimulus bits: {reset, valid, cmd[1:0], halt, load_use}
    localparam logic [5:0] S_NOP  = 6'b000000;
    localparam logic [5:0] S_RUN  = 6'b010100;
    localparam logic [5:0] S_STEP = 6'b011000;
    localparam logic [5:0] S_STOP = 6'b011100;
    localparam logic [5:0] S_HALT = 6'b000010;
    localparam logic [5:0] S_LUH  = 6'b000001;
    localparam logic [5:0] S_RST  = 6'b100000;

    // expected bits: {state[2:0], pc, if_id, pipe, flush, ready, done}
    localparam logic [7:0] E_IDLE   = {3'd0, 4'b0000, 2'b10};
    localparam logic [7:0] E_DONE   = {3'd0, 4'b0000, 2'b11};
    localparam logic [7:0] E_RUN    = {3'd1, 4'b1110, 2'b10};
    localparam logic [7:0] E_RSTALL = {3'd1, 4'b0011, 2'b10};
    localparam logic [7:0] E_STEP   = {3'd2, 4'b1110, 2'b00};
    localparam logic [7:0] E_SSTALL = {3'd2, 4'b0011, 2'b00};
    localparam logic [7:0] E_DRAIN  = {3'd3, 4'b0011, 2'b00};
    localparam logic [7:0] E_HALT   = {3'd4, 4'b0000, 2'b10};
    localparam logic [7:0] E_HALTD  = {3'd4, 4'b0000, 2'b11};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd = 2'b00;
    logic        halt = 1'b0;
    logic        luh = 1'b0;
    logic        cmd_ready, pc_enb, if_id_enb, pipe_enb, id_ex_flush, done;
    logic [2:0]  state;
    logic [31:0] cycle_count;

    logic [5:0] stim_q[$];
    logic [7:0] plan_q[$];
    logic [7:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipeline_run_controller dut (
        .i_clock           (clk),
        .i_reset           (rst),
        .i_cmd_valid       (cmd_valid),
        .i_cmd             (cmd),
        .o_cmd_ready       (cmd_ready),
        .i_halt_detected   (halt),
        .i_load_use_hazard (luh),
        .o_pc_enb          (pc_enb),
        .o_if_id_enb       (if_id_enb),
        .o_pipe_enb        (pipe_enb),
        .o_id_ex_flush     (id_ex_flush),
        .o_state           (state),
        .o_done            (done),
        .o_cycle_count     (cycle_count)
    );

    function automatic logic [7:0] observed();
        return {state, pc_enb, if_id_enb, pipe_enb, id_ex_flush, cmd_ready, done};
    endfunction

    function automatic logic [31:0] cnt_exp(input int n);
        return CNT_ON ? 32'(n) : 32'd0;
    endfunction

    task automatic add(input logic [5:0] s, input logic [7:0] e, input int reps = 1);
        for (int i = 0; i < reps; i++) begin
            stim_q.push_back(s);
            plan_q.push_back(e);
        end
    endtask

    // drive one cycle's inputs at the falling edge and log its expectation
    task automatic drive(input logic [5:0] s, input logic [7:0] e);
        @(negedge clk);
        {rst, cmd_valid, cmd, halt, luh} = s;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        drive(S_RST, E_IDLE);
        void'(exp_q.pop_front());
        drive(S_RST, E_IDLE);
        void'(exp_q.pop_front());
    endtask

    task automatic test_reset();
        logic [7:0] e;
        do_reset();
        add(S_NOP, E_IDLE, 2);
        for (int c = 0; stim_q.size() > 0; c++) begin
            drive(stim_q.pop_front(), plan_q.pop_front());
            #2;
            e = exp_q.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL reset cycle %0d: got %b expected %b", c, observed(), e);
            end
        end
        checks++;
        if (cycle_count !== 32'd0) begin
            errors++;
            $display("FAIL reset count: got %0d expected 0", cycle_count);
        end
    endtask

    task automatic test_run_stop();
        logic [7:0] e;
        do_reset();
        add(S_RUN, E_IDLE);
        add(S_NOP, E_RUN, 9);
        add(S_STOP, E_RUN);
        add(S_NOP, E_IDLE);
        add(S_STOP, E_IDLE);
        add(S_NOP, E_IDLE);
        for (int c = 0; stim_q.size() > 0; c++) begin
            drive(stim_q.pop_front(), plan_q.pop_front());
            #2;
            e = exp_q.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL run_stop cycle %0d: got %b expected %b", c, observed(), e);
            end
        end
        checks++;
        if (cycle_count !== cnt_exp(10)) begin
            errors++;
            $display("FAIL run_stop count: got %0d expected %0d", cycle_count, cnt_exp(10));
        end
    endtask

    task automatic test_step();
        logic [7:0] e;
        do_reset();
        add(S_STEP, E_IDLE);
        add(S_RUN, E_STEP);
        add(S_NOP, E_DONE);
        add(S_NOP, E_IDLE);
        add(S_STEP, E_IDLE);
        add(S_LUH, E_SSTALL);
        add(S_NOP, E_DONE);
        for (int c = 0; stim_q.size() > 0; c++) begin
            drive(stim_q.pop_front(), plan_q.pop_front());
            #2;
            e = exp_q.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL step cycle %0d: got %b expected %b", c, observed(), e);
            end
        end
        checks++;
        if (cycle_count !== cnt_exp(2)) begin
            errors++;
            $display("FAIL step count: got %0d expected %0d", cycle_count, cnt_exp(2));
        end
    endtask

    task automatic test_load_use();
        logic [7:0] e;
        do_reset();
        add(S_RUN, E_IDLE);
        add(S_NOP, E_RUN);
        add(S_LUH, E_RSTALL);
        add(S_NOP, E_RUN);
        add(S_STOP, E_RUN);
        add(S_NOP, E_IDLE);
        for (int c = 0; stim_q.size() > 0; c++) begin
            drive(stim_q.pop_front(), plan_q.pop_front());
            #2;
            e = exp_q.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL load_use cycle %0d: got %b expected %b", c, observed(), e);
            end
        end
        checks++;
        if (cycle_count !== cnt_exp(4)) begin
            errors++;
            $display("FAIL load_use count: got %0d expected %0d", cycle_count, cnt_exp(4));
        end
    endtask

    task automatic test_halt();
        logic [7:0] e;
        do_reset();
        add(S_RUN, E_IDLE);
        add(S_NOP, E_RUN);
        add(S_HALT, E_RUN);
        add(S_NOP, E_DRAIN);
        add(S_LUH, E_DRAIN);
        add(S_NOP, E_DRAIN);
        add(S_RUN, E_HALTD);
        add(S_NOP, E_HALT);
        add(S_STEP, E_HALT);
        add(S_NOP, E_HALT);
        for (int c = 0; stim_q.size() > 0; c++) begin
            drive(stim_q.pop_front(), plan_q.pop_front());
            #2;
            e = exp_q.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL halt cycle %0d: got %b expected %b", c, observed(), e);
            end
        end
        checks++;
        if (cycle_count !== cnt_exp(5)) begin
            errors++;
            $display("FAIL halt count: got %0d expected %0d", cycle_count, cnt_exp(5));
        end
    endtask

    task automatic test_halt_vs_stop();
        logic [7:0] e;
        do_reset();
        add(S_RUN, E_IDLE);
        add(S_STOP | S_HALT, E_RUN);
        add(S_NOP, E_DRAIN, 3);
        add(S_NOP, E_HALTD);
        for (int c = 0; stim_q.size() > 0; c++) begin
            drive(stim_q.pop_front(), plan_q.pop_front());
            #2;
            e = exp_q.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL halt_vs_stop cycle %0d: got %b expected %b", c, observed(), e);
            end
        end
    endtask

    task automatic test_halt_under_stall();
        logic [7:0] e;
        do_reset();
        add(S_RUN, E_IDLE);
        add(S_HALT | S_LUH, E_RSTALL);
        add(S_HALT, E_RUN);
        add(S_NOP, E_DRAIN, 3);
        add(S_NOP, E_HALTD);
        for (int c = 0; stim_q.size() > 0; c++) begin
            drive(stim_q.pop_front(), plan_q.pop_front());
            #2;
            e = exp_q.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL halt_under_stall cycle %0d: got %b expected %b", c, observed(), e);
            end
        end
        checks++;
        if (cycle_count !== cnt_exp(5)) begin
            errors++;
            $display("FAIL halt_under_stall count: got %0d expected %0d", cycle_count, cnt_exp(5));
        end
    endtask

    task automatic test_reset_in_drain();
        logic [7:0] e;
        do_reset();
        add(S_RUN, E_IDLE);
        add(S_HALT, E_RUN);
        add(S_NOP, E_DRAIN);
        add(S_RST, E_DRAIN);
        add(S_NOP, E_IDLE);
        for (int c = 0; stim_q.size() > 0; c++) begin
            drive(stim_q.pop_front(), plan_q.pop_front());
            #2;
            e = exp_q.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL reset_in_drain cycle %0d: got %b expected %b", c, observed(), e);
            end
        end
        checks++;
        if (cycle_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_in_drain count: got %0d expected 0", cycle_count);
        end
        add(S_STEP, E_IDLE);
        add(S_NOP, E_STEP);
        add(S_NOP, E_DONE);
        for (int c = 0; stim_q.size() > 0; c++) begin
            drive(stim_q.pop_front(), plan_q.pop_front());
            #2;
            e = exp_q.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL step_after_reset cycle %0d: got %b expected %b", c, observed(), e);
            end
        end
        checks++;
        if (cycle_count !== cnt_exp(1)) begin
            errors++;
            $display("FAIL step_after_reset count: got %0d expected %0d", cycle_count, cnt_exp(1));
        end
    endtask

    initial begin
        test_reset();
        test_run_stop();
        test_step();
        test_load_use();
        test_halt();
        test_halt_vs_stop();
        test_halt_under_stall();
        test_reset_in_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
